// File: rtl/seq_tx_if.sv
// Bundle for the seq_tx load handshake, serial stream and golden match count.
// master = word source / stream consumer, slave = the transmitter.
interface seq_tx_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             pause;
  logic             o_bit;
  logic             o_valid;
  logic             word_done;
  logic             busy;
  logic             clear_match;
  logic [CNT_W-1:0] exp_match;

  modport master (
    output load_data, load_valid, pause, clear_match,
    input  load_ready, o_bit, o_valid, word_done, busy, exp_match
  );

  modport slave (
    input  load_data, load_valid, pause, clear_match,
    output load_ready, o_bit, o_valid, word_done, busy, exp_match
  );
endinterface

// File: rtl/seq_tx.sv
// LSB-first serial word transmitter with a one-word holding buffer and a
// saturating golden count of overlapping 1101 patterns in the emitted stream.
module seq_tx #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic   clk,
  input  logic   rst,
  seq_tx_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [3:0]       PATTERN  = 4'b1101;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_buf;
  logic             r_buf_full;
  logic             r_load_ready;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_hist;
  logic [CNT_W-1:0] r_exp_match;

  logic       w_o_valid;
  logic       w_o_bit;
  logic       w_at_last;
  logic       w_accept;
  logic       w_transfer;
  logic [3:0] w_hist_next;
  logic       w_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign w_o_valid   = (r_state == ST_SHIFT) && !bus.pause;
  assign w_o_bit     = r_shift[r_idx];
  assign w_at_last   = (r_idx == LAST_IDX);
  assign w_accept    = bus.load_valid && r_load_ready;
  // Buffer hands over only on an unpaused edge that ends the current word (or from idle).
  assign w_transfer  = r_buf_full && !bus.pause && ((r_state == ST_IDLE) || w_at_last);
  assign w_hist_next = {r_hist[2:0], w_o_bit};
  assign w_hit       = w_o_valid && (w_hist_next == PATTERN);

  assign bus.load_ready = r_load_ready;
  assign bus.o_bit      = w_o_bit;
  assign bus.o_valid    = w_o_valid;
  assign bus.word_done  = w_o_valid && w_at_last;
  assign bus.busy       = (r_state == ST_SHIFT) || r_buf_full;
  assign bus.exp_match  = r_exp_match;

  // Buffer, shifter FSM and match model state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= {WIDTH{1'b0}};
      r_buf        <= {WIDTH{1'b0}};
      r_buf_full   <= 1'b0;
      r_load_ready <= 1'b1;
      r_idx        <= {IDX_W{1'b0}};
      r_hist       <= 4'b0000;
      r_exp_match  <= {CNT_W{1'b0}};
    end else begin
      if (w_transfer) begin
        r_buf_full   <= 1'b0;
        r_load_ready <= 1'b1;
      end else if (w_accept) begin
        r_buf        <= bus.load_data;
        r_buf_full   <= 1'b1;
        r_load_ready <= 1'b0;
      end else begin
        r_buf_full   <= r_buf_full;
        r_load_ready <= r_load_ready;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_transfer) begin
            r_shift <= r_buf;
            r_idx   <= {IDX_W{1'b0}};
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (bus.pause) begin
            r_state <= ST_SHIFT;
          end else if (!w_at_last) begin
            r_idx <= r_idx + IDX_W'(1);
          end else if (w_transfer) begin
            r_shift <= r_buf;
            r_idx   <= {IDX_W{1'b0}};
          end else begin
            r_idx   <= {IDX_W{1'b0}};
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= {IDX_W{1'b0}};
        end
      endcase

      // History persists across words and pauses; only rst clears it.
      if (w_o_valid) begin
        r_hist <= w_hist_next;
      end else begin
        r_hist <= r_hist;
      end

      if (bus.clear_match) begin
        r_exp_match <= {CNT_W{1'b0}};
      end else if (w_hit) begin
        r_exp_match <= sat_inc(r_exp_match);
      end else begin
        r_exp_match <= r_exp_match;
      end
    end
  end

endmodule
